// File: rtl/alu_cmd_pkg.sv
// =============================================================================
// Module      : alu_cmd_pkg
// Description : Shared constants for the ALU command controller: datapath
//               widths, UART command codes, ALU function codes and the FSM
//               state encoding.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package alu_cmd_pkg;

  localparam int C_DATA_WIDTH = 8;
  localparam int C_RES_WIDTH  = 2 * C_DATA_WIDTH;
  localparam int C_FUN_WIDTH  = 4;

  // Frame command codes (first byte of a frame)
  localparam logic [7:0] C_CMD_ALU_OP  = 8'hCC;  // CMD, A, B, FUN
  localparam logic [7:0] C_CMD_ALU_NOP = 8'hDD;  // CMD, FUN (reuse A/B)

  // ALU function codes understood by the downstream ALU
  localparam logic [3:0] C_FUN_ADD = 4'd0;
  localparam logic [3:0] C_FUN_SUB = 4'd1;
  localparam logic [3:0] C_FUN_MUL = 4'd2;
  localparam logic [3:0] C_FUN_DIV = 4'd3;
  localparam logic [3:0] C_FUN_AND = 4'd4;
  localparam logic [3:0] C_FUN_OR  = 4'd5;

  // FSM state encoding
  localparam logic [3:0] C_ST_IDLE     = 4'd0;
  localparam logic [3:0] C_ST_GET_A    = 4'd1;
  localparam logic [3:0] C_ST_GET_B    = 4'd2;
  localparam logic [3:0] C_ST_GET_FUN  = 4'd3;
  localparam logic [3:0] C_ST_ALU_RUN  = 4'd4;
  localparam logic [3:0] C_ST_ALU_WAIT = 4'd5;
  localparam logic [3:0] C_ST_TX_LSB   = 4'd6;
  localparam logic [3:0] C_ST_TX_GAP   = 4'd7;
  localparam logic [3:0] C_ST_TX_MSB   = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE     = C_ST_IDLE,
    ST_GET_A    = C_ST_GET_A,
    ST_GET_B    = C_ST_GET_B,
    ST_GET_FUN  = C_ST_GET_FUN,
    ST_ALU_RUN  = C_ST_ALU_RUN,
    ST_ALU_WAIT = C_ST_ALU_WAIT,
    ST_TX_LSB   = C_ST_TX_LSB,
    ST_TX_GAP   = C_ST_TX_GAP,
    ST_TX_MSB   = C_ST_TX_MSB
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_timer.sv
// =============================================================================
// Module      : alu_cmd_timer
// Description : Partial-frame timeout counter. Counts cycles while i_run is
//               high and no byte arrives; o_expired pulses in the cycle that
//               completes TIMEOUT_CYC idle cycles.
// Ports       : CLK, RST (async active-low), i_clr (byte strobe),
//               i_run (frame in progress), o_expired (timeout pulse)
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module alu_cmd_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expired
);

  localparam int                 C_CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(TIMEOUT_CYC - 1);

  logic [C_CNT_W-1:0] r_cnt;

  // The counter value equals the number of idle cycles already elapsed, so
  // the TIMEOUT_CYC-th idle cycle is the one that sees C_LIMIT.
  assign o_expired = i_run && !i_clr && (r_cnt == C_LIMIT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (i_clr || !i_run || o_expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_ctrl.sv
// =============================================================================
// Module      : alu_cmd_ctrl
// Description : UART command front end for the registered ALU. Parses RX
//               frames (CC,A,B,FUN or DD,FUN), pulses ALU_EN, captures the
//               result and returns it LSB first as two TX bytes.
// Ports       : CLK/RST (async active-low); RX_P_DATA/RX_D_VLD from the RX
//               synchronizer; ALU_OUT/ALU_OUT_VLD from the ALU; TX_BUSY from
//               the TX side; ALU_A/ALU_B/ALU_FUN/ALU_EN to the ALU;
//               TX_P_DATA/TX_D_VLD to TX; BUSY high whenever not IDLE.
// Config      : ALU_CMD_TIMEOUT_EN - abort partial frames after TIMEOUT_CYC
//               cycles without a byte (alu_cmd_timer).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module alu_cmd_ctrl
  import alu_cmd_pkg::*;
#(
  parameter int               DATA_WIDTH  = C_DATA_WIDTH,
  parameter int               RES_WIDTH   = 2 * DATA_WIDTH,
  parameter int               FUN_WIDTH   = C_FUN_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = C_CMD_ALU_OP,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = C_CMD_ALU_NOP,
  parameter int               TIMEOUT_CYC = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [RES_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  BUSY
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [FUN_WIDTH-1:0]  r_alu_fun;
  logic                  r_alu_en;
  logic [DATA_WIDTH-1:0] r_res_msb;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_vld;
  logic                  w_tx_accept;
  logic                  w_in_frame;
  logic                  w_timeout;

  assign w_tx_accept = r_tx_vld && !TX_BUSY;
  assign w_in_frame  = (r_state == ST_GET_A) || (r_state == ST_GET_B) ||
                       (r_state == ST_GET_FUN);

`ifdef ALU_CMD_TIMEOUT_EN
  // Operands of the last completed frame, restored when a frame is aborted.
  logic [DATA_WIDTH-1:0] r_last_a;
  logic [DATA_WIDTH-1:0] r_last_b;

  alu_cmd_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .CLK       (CLK),
    .RST       (RST),
    .i_clr     (RX_D_VLD),
    .i_run     (w_in_frame),
    .o_expired (w_timeout)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0) && w_in_frame;
  assign w_timeout            = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_ALU_OP) begin
            w_state_nxt = ST_GET_A;
          end else if (RX_P_DATA == CMD_ALU_NOP) begin
            w_state_nxt = ST_GET_FUN;
          end
        end
      end
      ST_GET_A:     if (RX_D_VLD)    w_state_nxt = ST_GET_B;
      ST_GET_B:     if (RX_D_VLD)    w_state_nxt = ST_GET_FUN;
      ST_GET_FUN:   if (RX_D_VLD)    w_state_nxt = ST_ALU_RUN;
      ST_ALU_RUN:                    w_state_nxt = ST_ALU_WAIT;
      ST_ALU_WAIT:  if (ALU_OUT_VLD) w_state_nxt = ST_TX_LSB;
      ST_TX_LSB:    if (w_tx_accept) w_state_nxt = ST_TX_GAP;
      // One dead cycle lets the TX side raise TX_BUSY after acceptance.
      ST_TX_GAP:                     w_state_nxt = ST_TX_MSB;
      ST_TX_MSB:    if (w_tx_accept) w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
      r_alu_en  <= 1'b0;
      r_res_msb <= '0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
`ifdef ALU_CMD_TIMEOUT_EN
      r_last_a  <= '0;
      r_last_b  <= '0;
`endif
    end else begin
      // The FUN byte strobe launches the ALU; EN is high throughout ALU_RUN.
      r_alu_en <= (r_state == ST_GET_FUN) && RX_D_VLD;
      unique case (r_state)
        ST_GET_A: if (RX_D_VLD) r_alu_a <= RX_P_DATA;
        ST_GET_B: if (RX_D_VLD) r_alu_b <= RX_P_DATA;
        ST_GET_FUN: begin
          if (RX_D_VLD) begin
            r_alu_fun <= RX_P_DATA[FUN_WIDTH-1:0];
`ifdef ALU_CMD_TIMEOUT_EN
            r_last_a  <= r_alu_a;
            r_last_b  <= r_alu_b;
`endif
          end
        end
        ST_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            r_res_msb <= ALU_OUT[RES_WIDTH-1:DATA_WIDTH];
            r_tx_data <= ALU_OUT[DATA_WIDTH-1:0];
            r_tx_vld  <= 1'b1;
          end
        end
        ST_TX_LSB, ST_TX_MSB: if (w_tx_accept) r_tx_vld <= 1'b0;
        ST_TX_GAP: begin
          r_tx_data <= r_res_msb;
          r_tx_vld  <= 1'b1;
        end
        default: ;
      endcase
`ifdef ALU_CMD_TIMEOUT_EN
      if (w_timeout) begin
        r_alu_a <= r_last_a;
        r_alu_b <= r_last_b;
      end
`endif
    end
  end

  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_FUN   = r_alu_fun;
  assign ALU_EN    = r_alu_en;
  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign BUSY      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
